// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for an 8-digit seven-segment display.
// Software writes go to a staging register and reach the active register only
// at a frame boundary, so a frame never mixes old and new data. At the start of
// each digit slot there is a dead-time window with every anode off. This
// window suppresses ghosting while the segment lines settle.

module seg7_scan_ctrl #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned DIGIT_HZ   = 8_000,
  parameter int unsigned DEAD_CYC   = 16,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] value_i,
  input  logic [7:0]  dp_i,
  input  logic [7:0]  en_i,
  input  logic        blank_lz_i,
  input  logic        we_i,
  output logic        pending_o,
  output logic        frame_o,
  output logic [15:0] D_7SEG,
  output logic [7:0]  EN_7SEG
);

  localparam int unsigned DIV   = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC);

  // Pin level that turns a segment or an anode off.
  localparam logic [7:0]  OFF8  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [15:0] OFF16 = {OFF8, OFF8};

  // A slot must be long enough to hold the dead window and at least one lit cycle.
  if (DIV <= DEAD_CYC + 1) begin : g_div_check
    $error("seg7_scan_ctrl: CLK_HZ/DIGIT_HZ must exceed DEAD_CYC+1");
  end

  // Scan position.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  // Staging and active copies of the display fields.
  logic [31:0] stg_value_q, stg_value_d;
  logic [7:0]  stg_dp_q, stg_dp_d;
  logic [7:0]  stg_en_q, stg_en_d;
  logic        stg_blz_q, stg_blz_d;
  logic [31:0] act_value_q, act_value_d;
  logic [7:0]  act_dp_q, act_dp_d;
  logic [7:0]  act_en_q, act_en_d;
  logic        act_blz_q, act_blz_d;

  logic pending_q, pending_d;
  logic frame_q, frame_d;

  // Registered pin drivers.
  logic [15:0] seg_q, seg_d;
  logic [7:0]  an_q, an_d;

  logic tick;
  logic boundary;
  logic apply;

  // Prescaler, digit index, staging/active transfer and pending flag.
  always_comb begin
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stg_value_d = stg_value_q;
    stg_dp_d    = stg_dp_q;
    stg_en_d    = stg_en_q;
    stg_blz_d   = stg_blz_q;
    act_value_d = act_value_q;
    act_dp_d    = act_dp_q;
    act_en_d    = act_en_q;
    act_blz_d   = act_blz_q;
    pending_d   = pending_q;

    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == 3'd7);
    apply    = boundary && pending_q;

    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // The active register takes the old staging contents. A write in the same
    // cycle replaces staging afterwards and leaves pending set.
    if (apply) begin
      act_value_d = stg_value_q;
      act_dp_d    = stg_dp_q;
      act_en_d    = stg_en_q;
      act_blz_d   = stg_blz_q;
      pending_d   = 1'b0;
    end

    if (we_i) begin
      stg_value_d = value_i;
      stg_dp_d    = dp_i;
      stg_en_d    = en_i;
      stg_blz_d   = blank_lz_i;
      pending_d   = 1'b1;
    end

    frame_d = apply;
  end

  logic [8:0] zero_from;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic       lz_blank;
  logic       slot_on;
  logic       dead;

  // Pattern and anode selection for the current slot, based on the active register.
  always_comb begin
    // zero_from[k] is set when nibbles k..7 are all zero.
    zero_from[8] = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      zero_from[k] = (act_value_q[4*k +: 4] == 4'h0) && zero_from[k+1];
    end

    cur_nib = act_value_q[{idx_q, 2'b00} +: 4];

    unique case (cur_nib)
      4'h0: cur_seg = 7'h3F;
      4'h1: cur_seg = 7'h06;
      4'h2: cur_seg = 7'h5B;
      4'h3: cur_seg = 7'h4F;
      4'h4: cur_seg = 7'h66;
      4'h5: cur_seg = 7'h6D;
      4'h6: cur_seg = 7'h7D;
      4'h7: cur_seg = 7'h07;
      4'h8: cur_seg = 7'h7F;
      4'h9: cur_seg = 7'h6F;
      4'hA: cur_seg = 7'h77;
      4'hB: cur_seg = 7'h7C;
      4'hC: cur_seg = 7'h39;
      4'hD: cur_seg = 7'h5E;
      4'hE: cur_seg = 7'h79;
      4'hF: cur_seg = 7'h71;
      default: cur_seg = 7'h00;
    endcase

    // Digit 0 always stays visible, so a zero value still shows "0".
    lz_blank = act_blz_q && (idx_q != 3'd0) && zero_from[idx_q];
    slot_on  = act_en_q[idx_q] && !lz_blank;
    dead     = (cnt_q < DEAD_END);

    seg_d = OFF16;
    an_d  = OFF8;
    // During dead time the segments are already driven; only the anodes are held off.
    if (slot_on) begin
      seg_d = {2{{act_dp_q[idx_q], cur_seg} ^ OFF8}};
      if (!dead) begin
        an_d = (8'b1 << idx_q) ^ OFF8;
      end
    end
  end

  // State registers with synchronous reset. Reset also discards staged data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      stg_value_q <= 32'h0;
      stg_dp_q    <= 8'h00;
      stg_en_q    <= 8'h00;
      stg_blz_q   <= 1'b0;
      act_value_q <= 32'h0;
      act_dp_q    <= 8'h00;
      act_en_q    <= 8'h00;
      act_blz_q   <= 1'b0;
      pending_q   <= 1'b0;
      frame_q     <= 1'b0;
      seg_q       <= OFF16;
      an_q        <= OFF8;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stg_value_q <= stg_value_d;
      stg_dp_q    <= stg_dp_d;
      stg_en_q    <= stg_en_d;
      stg_blz_q   <= stg_blz_d;
      act_value_q <= act_value_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      act_blz_q   <= act_blz_d;
      pending_q   <= pending_d;
      frame_q     <= frame_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign pending_o = pending_q;
  assign frame_o   = frame_q;
  assign D_7SEG    = seg_q;
  assign EN_7SEG   = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: DIV=10, DEAD_CYC=2, active-low pins.
// The reference model tracks cycles since reset. It derives slot and position
// with modular arithmetic and applies the staging/active rules directly.

module tb_seg7_scan_ctrl;

  localparam int unsigned DIV   = 10;
  localparam int unsigned DEAD  = 2;
  localparam int unsigned FRAME = DIV * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  en;
  logic        blz;
  logic        we;
  logic        pending;
  logic        frame;
  logic [15:0] d7;
  logic [7:0]  en7;

  seg7_scan_ctrl #(
    .CLK_HZ    (1000),
    .DIGIT_HZ  (100),
    .DEAD_CYC  (2),
    .ACTIVE_LOW(1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .value_i   (value),
    .dp_i      (dp),
    .en_i      (en),
    .blank_lz_i(blz),
    .we_i      (we),
    .pending_o (pending),
    .frame_o   (frame),
    .D_7SEG    (d7),
    .EN_7SEG   (en7)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [31:0] s_val, a_val;
  logic [7:0]  s_dp, a_dp, s_en, a_en;
  logic        s_blz, a_blz;
  logic        m_pend, m_frame;
  logic [7:0]  m_en;
  logic [15:0] m_d;
  int unsigned m_t;
  int unsigned m_shown;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[n];
  endfunction

  // Advance one clock. Update the model from the inputs seen at that edge,
  // then wait until the outputs have settled.
  task automatic tick();
    int unsigned pos, k, c;
    logic        on;
    logic [7:0]  pat;
    @(posedge clk);
    if (rst) begin
      m_t = 0; s_val = 0; a_val = 0; s_dp = 0; a_dp = 0; s_en = 0; a_en = 0;
      s_blz = 0; a_blz = 0; m_pend = 0; m_frame = 0; m_en = 8'hFF; m_d = 16'hFFFF;
      m_shown = 0;
    end else begin
      pos = m_t % FRAME;
      k   = pos / DIV;
      c   = pos % DIV;
      on  = a_en[k] && !(a_blz && k > 0 && (a_val >> (4 * k)) == 32'h0);
      pat = {a_dp[k], seg_of(a_val[4*k +: 4])};
      m_d  = on ? {~pat, ~pat} : 16'hFFFF;
      m_en = (on && c >= DEAD) ? ~(8'b1 << k) : 8'hFF;
      m_shown = pos;
      m_frame = (pos == FRAME - 1) && m_pend;
      if (m_frame) begin
        a_val = s_val; a_dp = s_dp; a_en = s_en; a_blz = s_blz; m_pend = 0;
      end
      if (we) begin
        s_val = value; s_dp = dp; s_en = en; s_blz = blz; m_pend = 1;
      end
      m_t++;
    end
    #1;
  endtask

  task automatic write(input logic [31:0] v, input logic [7:0] d, input logic [7:0] e,
                       input logic b);
    value = v; dp = d; en = e; blz = b; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; value = 32'h0; dp = 8'h0; en = 8'h0; blz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({en7, d7, pending, frame} !== {8'hFF, 16'hFFFF, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got en=%h d=%h p=%b f=%b want en=ff d=ffff p=0 f=0",
                 i, en7, d7, pending, frame);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_digits();
    int unsigned i;
    write(32'h0000_1234, 8'h00, 8'hFF, 1'b0);
    n_tests++;
    if (pending !== 1'b1) begin
      n_fail++; $display("FAIL digits_pending got %b want 1", pending);
    end
    for (i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_tests++;
      if ({en7, d7, pending, frame} !== {m_en, m_d, m_pend, m_frame}) begin
        n_fail++;
        $display("FAIL digits_model pos=%0d got en=%h d=%h p=%b f=%b want en=%h d=%h p=%b f=%b",
                 m_shown, en7, d7, pending, frame, m_en, m_d, m_pend, m_frame);
      end
      if (m_frame) break;
    end
    n_tests++;
    if (!(frame === 1'b1 && pending === 1'b0)) begin
      n_fail++; $display("FAIL digits_apply got f=%b p=%b want f=1 p=0", frame, pending);
    end
    for (i = 0; i < FRAME; i++) begin
      tick();
      if (m_shown == 5 || m_shown == 35 || m_shown == 45 || m_shown == 75) begin
        n_tests++;
        case (m_shown)
          5:  if ({en7, d7} !== {8'hFE, 16'h9999}) begin
                n_fail++; $display("FAIL digit0 got en=%h d=%h want en=fe d=9999", en7, d7);
              end
          35: if ({en7, d7} !== {8'hF7, 16'hF9F9}) begin
                n_fail++; $display("FAIL digit3 got en=%h d=%h want en=f7 d=f9f9", en7, d7);
              end
          45: if ({en7, d7} !== {8'hEF, 16'hC0C0}) begin
                n_fail++; $display("FAIL digit4 got en=%h d=%h want en=ef d=c0c0", en7, d7);
              end
          default: if ({en7, d7} !== {8'h7F, 16'hC0C0}) begin
                n_fail++; $display("FAIL digit7 got en=%h d=%h want en=7f d=c0c0", en7, d7);
              end
        endcase
      end
    end
  endtask

  task automatic test_blank_lz();
    write(32'h0000_1234, 8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (m_frame) break;
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (m_shown >= 40 && en7 !== 8'hFF) begin
        n_fail++; $display("FAIL lz_blank pos=%0d got en=%h want ff", m_shown, en7);
      end else if ({en7, d7} !== {m_en, m_d}) begin
        n_fail++;
        $display("FAIL lz_model pos=%0d got en=%h d=%h want en=%h d=%h", m_shown, en7, d7, m_en, m_d);
      end
    end
    write(32'h0, 8'h00, 8'hFF, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (m_frame) break;
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if (m_shown < DIV) begin
        if (m_shown >= DEAD && {en7, d7} !== {8'hFE, 16'hC0C0}) begin
          n_fail++; $display("FAIL zero_digit0 pos=%0d got en=%h d=%h want en=fe d=c0c0",
                             m_shown, en7, d7);
        end
      end else if ({en7, d7} !== {8'hFF, 16'hFFFF}) begin
        n_fail++; $display("FAIL zero_blank pos=%0d got en=%h d=%h want en=ff d=ffff",
                           m_shown, en7, d7);
      end
    end
  endtask

  task automatic test_dead_time();
    int unsigned k, c;
    write(32'h8765_4321, 8'($urandom), 8'hFF, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (m_frame) break;
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        tick();
        k = m_shown / DIV;
        c = m_shown % DIV;
        n_tests++;
        if (en7 !== ((c < DEAD) ? 8'hFF : ~(8'b1 << k))) begin
          n_fail++; $display("FAIL dead_time pos=%0d got en=%h", m_shown, en7);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va, vb;
    int          guard;
    va = $urandom; vb = $urandom;
    guard = 0;
    while (m_t % FRAME != FRAME - 2 && guard < 2 * FRAME) begin
      tick(); guard++;
    end
    write(va, 8'h0F, 8'hFF, 1'b0);
    write(vb, 8'hF0, 8'hFF, 1'b0);
    n_tests++;
    if (!(frame === 1'b1 && pending === 1'b1 && a_val === va)) begin
      n_fail++; $display("FAIL b2b_first got f=%b p=%b want f=1 p=1", frame, pending);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      n_tests++;
      if ({en7, d7, pending, frame} !== {m_en, m_d, m_pend, m_frame}) begin
        n_fail++;
        $display("FAIL b2b_model pos=%0d got en=%h d=%h p=%b f=%b want en=%h d=%h p=%b f=%b",
                 m_shown, en7, d7, pending, frame, m_en, m_d, m_pend, m_frame);
      end
    end
    n_tests++;
    if (!(frame === 1'b1 && pending === 1'b0 && a_val === vb)) begin
      n_fail++; $display("FAIL b2b_second got f=%b p=%b want f=1 p=0", frame, pending);
    end
  endtask

  task automatic test_reset_mid();
    write($urandom, 8'($urandom), 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({en7, d7, pending, frame} !== {8'hFF, 16'hFFFF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid got en=%h d=%h p=%b f=%b want en=ff d=ffff p=0 f=0",
                         en7, d7, pending, frame);
    end
    for (int i = 0; i < FRAME + 10; i++) begin
      tick();
      n_tests++;
      if (frame !== 1'b0 || pending !== 1'b0 || {en7, d7} !== {m_en, m_d}) begin
        n_fail++; $display("FAIL reset_mid_after pos=%0d got f=%b p=%b en=%h want f=0 p=0 en=%h",
                           m_shown, frame, pending, en7, m_en);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 7));
        value = v; dp = 8'($urandom); en = 8'($urandom); blz = 1'($urandom); we = 1'b1;
      end else begin
        we = 1'b0;
      end
      tick();
      n_tests++;
      if ({en7, d7, pending, frame} !== {m_en, m_d, m_pend, m_frame}) begin
        n_fail++;
        $display("FAIL random pos=%0d got en=%h d=%h p=%b f=%b want en=%h d=%h p=%b f=%b",
                 m_shown, en7, d7, pending, frame, m_en, m_d, m_pend, m_frame);
      end
    end
    we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_digits();
    test_blank_lz();
    test_dead_time();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
